// File: rtl/sb_io_bus_arbiter.sv
// sb_io_bus_arbiter
// Round-robin arbiter sharing one bidirectional SB_IO pad bus (registered
// tristate mode) between NREQ requesters. Sequences output enable and drive
// data, captures read data, and inserts idle turnaround cycles whenever the
// transfer direction changes.
//
// Ports
//   C       clock, rising edge
//   R_N     asynchronous active-low reset
//   REQ     per-requester level request, held for the whole burst
//   WR      per-requester direction (1 = drive pads), sampled at arbitration
//   WDATA   write data, slice i belongs to requester i
//   GNT     one-hot grant, zero when idle
//   RDATA   captured read data
//   RVALID  one-cycle pulse qualifying RDATA
//   RSEL    index of the requester owning the current grant / RDATA
//   OE      to SB_IO OUTPUT_ENABLE
//   D_OUT   to SB_IO D_OUT_0
//   D_IN    from SB_IO D_IN_0
//   BUSY    high whenever the arbiter is not idle
module sb_io_bus_arbiter #(
   parameter int unsigned NREQ       = 4,
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned TURNAROUND = 1,
   parameter int unsigned MAX_BURST  = 16
) (
   input  logic                    C,
   input  logic                    R_N,
   input  logic [NREQ-1:0]         REQ,
   input  logic [NREQ-1:0]         WR,
   input  logic [NREQ*WIDTH-1:0]   WDATA,
   output logic [NREQ-1:0]         GNT,
   output logic [WIDTH-1:0]        RDATA,
   output logic                    RVALID,
   output logic [$clog2(NREQ)-1:0] RSEL,
   output logic                    OE,
   output logic [WIDTH-1:0]        D_OUT,
   input  logic [WIDTH-1:0]        D_IN,
   output logic                    BUSY
);

   localparam int unsigned SELW = $clog2(NREQ);
   localparam int unsigned CNTW = $clog2(MAX_BURST + 1);
   localparam int unsigned TCW  = 3;

   localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(MAX_BURST - 1);
   localparam logic [NREQ-1:0] ONE_HOT0  = NREQ'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TURN = 2'd1,
      XFER = 2'd2
   } state_t;

   state_t          state;
   logic            dir;        // direction of the bus as last set up
   logic            ndir;       // direction requested by the pending grant
   logic [SELW-1:0] ptr;        // round-robin scan start
   logic [CNTW-1:0] beat_cnt;
   logic [TCW-1:0]  turn_cnt;

   // Unpack the write-data bus so the granted slice can be indexed by RSEL
   logic [WIDTH-1:0] wdata_a [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_wdata
      assign wdata_a[g] = WDATA[g*WIDTH +: WIDTH];
   end

   // Round-robin pick: first set request scanning ptr, ptr+1, ... mod NREQ
   logic [SELW-1:0] pick_sel_c;
   logic            pick_vld_c;

   always_comb begin
      logic [SELW-1:0] idx;
      idx        = '0;
      pick_sel_c = '0;
      pick_vld_c = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = SELW'((32'(ptr) + k) % NREQ);
         if (!pick_vld_c && REQ[idx]) begin
            pick_vld_c = 1'b1;
            pick_sel_c = idx;
         end
      end
   end

   // Next round-robin start after the current owner releases the bus
   logic [SELW-1:0] ptr_next_c;
   assign ptr_next_c = (32'(RSEL) == NREQ - 1) ? '0 : RSEL + 1'b1;

   // Arbitration / turnaround / transfer sequencer with registered outputs
   always_ff @(posedge C or negedge R_N) begin
      if (!R_N) begin
         state    <= IDLE;
         dir      <= 1'b0;
         ndir     <= 1'b0;
         ptr      <= '0;
         beat_cnt <= '0;
         turn_cnt <= '0;
         GNT      <= '0;
         RDATA    <= '0;
         RVALID   <= 1'b0;
         RSEL     <= '0;
         OE       <= 1'b0;
         D_OUT    <= '0;
         BUSY     <= 1'b0;
      end else begin
         RVALID <= 1'b0;
         unique case (state)
            IDLE: begin
               // Clears a pad enable left over from a write beat on the exit edge
               OE <= 1'b0;
               if (pick_vld_c) begin
                  RSEL <= pick_sel_c;
                  ndir <= WR[pick_sel_c];
                  BUSY <= 1'b1;
                  if ((WR[pick_sel_c] != dir) && (TURNAROUND != 0)) begin
                     state    <= TURN;
                     turn_cnt <= TCW'(TURNAROUND);
                  end else begin
                     state <= XFER;
                     GNT   <= ONE_HOT0 << pick_sel_c;
                     dir   <= WR[pick_sel_c];
                  end
               end
            end

            TURN: begin
               OE <= 1'b0;
               if (!REQ[RSEL]) begin
                  // Abandoned before the grant: the bus still settles to the new direction
                  state <= IDLE;
                  BUSY  <= 1'b0;
                  dir   <= ndir;
               end else if (turn_cnt <= TCW'(1)) begin
                  state <= XFER;
                  GNT   <= ONE_HOT0 << RSEL;
                  dir   <= ndir;
               end else begin
                  turn_cnt <= turn_cnt - 1'b1;
               end
            end

            XFER: begin
               if (GNT[RSEL] && REQ[RSEL]) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (dir) begin
                     D_OUT <= wdata_a[RSEL];
                     OE    <= 1'b1;
                  end else begin
                     RDATA  <= D_IN;
                     RVALID <= 1'b1;
                     OE     <= 1'b0;
                  end
                  if (beat_cnt == LAST_BEAT) begin
                     state    <= IDLE;
                     BUSY     <= 1'b0;
                     GNT      <= '0;
                     ptr      <= ptr_next_c;
                     beat_cnt <= '0;
                  end
               end else begin
                  OE       <= 1'b0;
                  state    <= IDLE;
                  BUSY     <= 1'b0;
                  GNT      <= '0;
                  ptr      <= ptr_next_c;
                  beat_cnt <= '0;
               end
            end

            default: begin
               state <= IDLE;
               BUSY  <= 1'b0;
               GNT   <= '0;
               OE    <= 1'b0;
            end
         endcase
      end
   end

   gnt_onehot_a: assert property (@(posedge C) disable iff (!R_N) $onehot0(GNT));

endmodule

// File: doc/sb_io_bus_arbiter.md
Name: sb_io_bus_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit bidirectional pad bus between NREQ requesters.
- The pad bus is built from SB_IO cells in registered tristate mode.
- Sequences output-enable and drive data, captures read data, and inserts bus-turnaround cycles whenever transfer direction changes.
- Sits between the user logic (requesters) and the SB_IO D_OUT_0 / OUTPUT_ENABLE / D_IN_0 pins.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, pad bus width in bits.
- TURNAROUND, 1, idle cycles with OE=0 inserted on a direction change (0..7).
- MAX_BURST, 16, maximum beats per grant before forced re-arbitration (1..256).

Ports:
- C  in  1  clock, rising edge.
- R_N  in  1  reset; asynchronous assert, active-low.
- REQ  in  NREQ  per-requester request, level; held for the whole burst.
- WR  in  NREQ  per-requester direction: 1 = drive pads, 0 = read pads; sampled at grant only.
- WDATA  in  NREQ*WIDTH  write data; slice i belongs to requester i.
- GNT  out  NREQ  one-hot grant; all-zero when no grant.
- RDATA  out  WIDTH  captured read data.
- RVALID  out  1  one-cycle pulse, RDATA valid.
- RSEL  out  clog2(NREQ)  requester index that owns RDATA / current grant.
- OE  out  1  to SB_IO OUTPUT_ENABLE (all bits).
- D_OUT  out  WIDTH  to SB_IO D_OUT_0.
- D_IN  in  WIDTH  from SB_IO D_IN_0.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (R_N=0, asynchronous):
  - State=IDLE; GNT=0, OE=0, D_OUT=0, RDATA=0, RVALID=0, RSEL=0, BUSY=0.
  - Direction register DIR=0 (read); round-robin pointer PTR=0; beat counter=0.
  - OE clears without waiting for a clock edge (pad safety). Reset mid-burst abandons the burst; no further beats.
- All outputs are registered.
- States: IDLE, TURN, XFER.
- IDLE:
  - If any REQ, select the first set REQ scanning PTR, PTR+1, ... mod NREQ. Latch index into RSEL and latch WR[sel] as NDIR.
  - If NDIR != DIR and TURNAROUND>0: go to TURN, load turn counter=TURNAROUND, set OE=0.
  - Otherwise: go to XFER with GNT[sel]=1 on the next cycle. DIR <= NDIR.
  - No REQ: stay in IDLE.
- TURN:
  - OE=0, GNT=0. Counter decrements each cycle; at 1, go to XFER and set DIR <= NDIR.
  - If REQ[RSEL] drops during TURN: go to IDLE, DIR still updated, PTR unchanged, no beats.
- XFER, beat rule: a beat occurs at every rising edge where GNT[RSEL]=1 and REQ[RSEL]=1.
  - Write beat (DIR=1): D_OUT <= WDATA slice RSEL, OE <= 1; the pad is driven in the following cycle.
  - Read beat (DIR=0): RDATA <= D_IN, RVALID <= 1 for one cycle, OE stays 0.
  - Beat counter increments per beat.
- XFER, exit:
  - Exit when REQ[RSEL]=0 at an edge, or on the edge completing beat MAX_BURST.
  - On exit: GNT <= 0, PTR <= RSEL+1 mod NREQ, beat counter <= 0, state <= IDLE.
  - OE <= 0 on the exit edge unless that edge is itself a write beat; in that case OE stays 1 one more cycle, then clears.
- Grant spacing: at least one IDLE cycle between consecutive grants. Same-direction back-to-back grants add no TURN.
- Simultaneous requests: round-robin only. A requester asserting REQ while another holds GNT waits; no preemption except MAX_BURST.
- WR changes during a grant are ignored. WDATA of non-granted requesters is ignored.
- GNT is always one-hot or zero. OE=1 only in the cycle after a write beat.

Test Plan:
- Reset mid-write: REQ[0]=1, WR[0]=1, WDATA[0]=8'hA5, assert R_N=0 mid-cycle during XFER -> OE=0 and GNT=0 immediately, before the next edge; after release, BUSY=0.
- Single read: REQ[2]=1, WR=0, D_IN=8'h3C held for 3 beats, then REQ[2]=0 -> GNT=4'b0100, three RVALID pulses with RDATA=8'h3C and RSEL=2, OE never 1, no TURN (DIR reset=read).
- Turnaround: requester 0 write burst of 2 beats (8'h11, 8'h22), then requester 1 read, TURNAROUND=1 -> D_OUT 8'h11 then 8'h22 with OE=1 for exactly 2 cycles; one IDLE plus one TURN cycle with OE=0; then GNT=4'b0010.
- Round-robin fairness: REQ=4'b1111 held, all WR=0, one beat each -> grant order 0,1,2,3,0; PTR wraps 3->0.
- MAX_BURST=4, REQ[1] held continuously while REQ[3]=1 -> exactly 4 beats to requester 1, then GNT=4'b1000 after one IDLE cycle.
- REQ drop in TURN: previous direction write, REQ[3] read asserted then dropped during TURN -> return to IDLE, no RVALID, next arbitration still starts at the old PTR.
